datapath_seq: RTL and testbench
===============================

// Module: datapath_seq
// PURPOSE
//  Parametrised successor to the lab datapath. Contains the register file, A/B/C pipeline
//  registers, the shifter, the ALU and N/Z/V status. A built-in sequencer runs one
//  instruction per start/done handshake, so no external loada/loadb/loadc/write strobing.
//  Sits between the upcoming instruction decoder and the memory/IO stage.
// PARAMETERS
//  W     16  datapath, register and immediate width (>=4)
//  NREG  8   register-file entries (power of 2); RW = $clog2(NREG)
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  start         in   1      request; accepted only in IDLE
//  mode          in   2      00 MOVI, 01 MOV, 10 ALU, 11 CMP
//  aluop         in   2      00 ADD, 01 SUB, 10 AND, 11 NOT B (ALU mode only)
//  shift         in   2      B-operand shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//  rd,rn,rm      in   RW     dest / A-source / B-source register indices
//  imm           in   W      MOVI immediate
//  busy          out  1      high while FSM != IDLE
//  done          out  1      one-cycle completion pulse
//  datapath_out  out  W      C register
//  z_out,n_out,v_out out 1   status flags
// BEHAVIOUR
//  Reset (async, rst_n=0): all NREG registers, A, B, C, status = 0; FSM=IDLE; busy=done=0.
//  Reset mid-operation aborts immediately; no writeback ever occurs for the aborted op.
//  Accept: start=1 at a rising edge with FSM=IDLE latches mode/aluop/shift/rd/rn/rm/imm.
//  Fields are ignored after accept. start while busy is ignored (not queued).
//  FSM states: IDLE, LDA, LDB, EXEC, WB.
//   MOVI: IDLE->WB (R[rd]=imm)->IDLE.                 busy 1 cycle
//   MOV : IDLE->LDB->EXEC->WB->IDLE.                  busy 3 cycles
//   ALU : IDLE->LDA->LDB->EXEC->WB->IDLE.             busy 4 cycles
//   CMP : IDLE->LDA->LDB->EXEC->IDLE. No writeback.   busy 3 cycles
//  LDA: A<=R[rn]. LDB: B<=R[rm]. EXEC: C<=result. WB: R[rd]<=C (R[rd]<=imm for MOVI).
//  done=1 for exactly the cycle after the edge that returns FSM to IDLE. busy=0 in that cycle.
//  start in that done cycle is accepted (back-to-back ops, no bubble).
//  Operand Bs = shift(B). LSL/LSR fill with 0. ASR replicates B[W-1].
//  MOV: result = Bs. A is not used.
//  ALU: ADD A+Bs, SUB A-Bs, AND A&Bs, NOT ~Bs. Arithmetic is modulo 2^W.
//  CMP: always computes A-Bs. C is not updated. Only status changes.
//  Status updates at EXEC of ALU and CMP only. MOVI and MOV leave N/Z/V unchanged.
//   Z = (result==0).
//   N = result[W-1].
//   V = signed overflow for ADD/SUB; V = 0 for AND/NOT.
//  Register reads happen before writeback, so rd==rn or rd==rm is legal.
//  Otherwise the register file and C hold their values.
// TESTING (W=16, NREG=8 unless noted)
//  1 Reset: release rst_n. Check datapath_out=0, flags 0, busy=0.
//    Then MOV R3,R0 -> out=0 and done pulses 3 cycles after accept.
//  2 MOVI R0,#7; MOVI R1,#2; ALU ADD R2,R1,R0,LSL1.
//    -> out=16, Z=N=V=0, busy 4 cycles, single done pulse.
//    Then MOV R3,R2 -> out=16.
//  3 CMP R1,R1 -> Z=1, N=0, V=0; out stays 16; no register changes (MOV R1 check -> 2).
//  4 MOVI R4,#0x7FFF; MOVI R5,#1; ADD R6,R4,R5 -> 0x8000, N=1, V=1.
//    Then MOV R7,R6,ASR1 -> 0xC000 with flags unchanged.
//    Then NOT R7,R7 -> 0x3FFF, V=0.
//  5 start held during a busy ALU op -> ignored.
//    start in the done cycle -> accepted; the next op's busy rises the following cycle.
//  6 rst_n low during EXEC of ADD R2 -> busy/done 0 at once.
//    After release, MOV R3,R2 -> 0. Repeat test 2 with W=8, NREG=16, using index 15.

Source files
------------

// File: rtl/datapath_seq.sv
// Sequenced datapath: register file, A/B/C registers, B shifter, ALU, N/Z/V.
// One instruction runs per start/done handshake.
module datapath_seq #(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [1:0]              aluop,
  input  logic [1:0]              shift,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [$clog2(NREG)-1:0] rn,
  input  logic [$clog2(NREG)-1:0] rm,
  input  logic [W-1:0]            imm,
  output logic                    busy,
  output logic                    done,
  output logic [W-1:0]            datapath_out,
  output logic                    z_out,
  output logic                    n_out,
  output logic                    v_out
);

  localparam int RW = $clog2(NREG);

  localparam logic [1:0] M_MOVI = 2'b00;
  localparam logic [1:0] M_MOV  = 2'b01;
  localparam logic [1:0] M_ALU  = 2'b10;
  localparam logic [1:0] M_CMP  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, LDA, LDB, EXEC, WB
  } state_t;

  state_t         state;
  logic [W-1:0]   rf [NREG];
  logic [W-1:0]   a_q, b_q, c_q;
  logic [W-1:0]   imm_q;
  logic [1:0]     mode_q, op_q, sh_q;
  logic [RW-1:0]  rd_q, rn_q, rm_q;
  logic           z_q, n_q, v_q;

  logic [W-1:0]   bs, res;
  logic           v_res;
  logic           is_add, is_sub, is_and, is_not;

  assign is_add = (mode_q == M_ALU) && (op_q == OP_ADD);
  assign is_sub = (mode_q == M_CMP) ||
                  ((mode_q == M_ALU) && (op_q == OP_SUB));
  assign is_and = (mode_q == M_ALU) && (op_q == OP_AND);
  assign is_not = (mode_q == M_ALU) && (op_q == OP_NOT);

  always_comb begin
    case (sh_q)
      2'b00:   bs = b_q;
      2'b01:   bs = {b_q[W-2:0], 1'b0};
      2'b10:   bs = {1'b0, b_q[W-1:1]};
      default: bs = {b_q[W-1], b_q[W-1:1]};
    endcase
  end

  // Overflow: operands agree in sign (ADD) or differ (SUB) and result sign flips.
  always_comb begin
    res   = bs;
    v_res = 1'b0;
    unique case (1'b1)
      is_add: begin
        res   = a_q + bs;
        v_res = ~(a_q[W-1] ^ bs[W-1]) & (res[W-1] ^ a_q[W-1]);
      end
      is_sub: begin
        res   = a_q - bs;
        v_res = (a_q[W-1] ^ bs[W-1]) & (res[W-1] ^ a_q[W-1]);
      end
      is_and:  res = a_q & bs;
      is_not:  res = ~bs;
      default: res = bs;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      imm_q  <= '0;
      mode_q <= '0;
      op_q   <= '0;
      sh_q   <= '0;
      rd_q   <= '0;
      rn_q   <= '0;
      rm_q   <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            op_q   <= aluop;
            sh_q   <= shift;
            rd_q   <= rd;
            rn_q   <= rn;
            rm_q   <= rm;
            imm_q  <= imm;
            busy   <= 1'b1;
            unique case (1'b1)
              (mode == M_MOVI): state <= WB;
              (mode == M_MOV):  state <= LDB;
              default:          state <= LDA;
            endcase
          end
        end
        LDA: begin
          a_q   <= rf[rn_q];
          state <= LDB;
        end
        LDB: begin
          b_q   <= rf[rm_q];
          state <= EXEC;
        end
        EXEC: begin
          if (mode_q != M_CMP)
            c_q <= res;
          if (mode_q[1]) begin
            z_q <= (res == '0);
            n_q <= res[W-1];
            v_q <= v_res;
          end
          if (mode_q == M_CMP) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= WB;
          end
        end
        WB: begin
          rf[rd_q] <= (mode_q == M_MOVI) ? imm_q : c_q;
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign datapath_out = c_q;
  assign z_out        = z_q;
  assign n_out        = n_q;
  assign v_out        = v_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: W=16/NREG=8 and W=8/NREG=16 instances.
// Driver queues expected results; a forked monitor checks them on done.
module tb_datapath_seq;

  localparam logic [1:0] MOVI = 2'd0, MOV = 2'd1, ALU = 2'd2, CMP = 2'd3;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2, OP_NOT = 2'd3;
  localparam logic [1:0] NS = 2'd0, LSL = 2'd1, LSR = 2'd2, ASR = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start1;
  logic [1:0]  mode1, aluop1, shift1;
  logic [2:0]  rd1, rn1, rm1;
  logic [15:0] imm1, out1;
  logic        busy1, done1, z1, n1, v1;

  logic        start2;
  logic [1:0]  mode2, aluop2, shift2;
  logic [3:0]  rd2, rn2, rm2;
  logic [7:0]  imm2, out2;
  logic        busy2, done2, z2, n2, v2;

  datapath_seq #(.W(16), .NREG(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .mode(mode1), .aluop(aluop1), .shift(shift1),
    .rd(rd1), .rn(rn1), .rm(rm1), .imm(imm1),
    .busy(busy1), .done(done1), .datapath_out(out1),
    .z_out(z1), .n_out(n1), .v_out(v1)
  );

  datapath_seq #(.W(8), .NREG(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .mode(mode2), .aluop(aluop2), .shift(shift2),
    .rd(rd2), .rn(rn2), .rm(rm2), .imm(imm2),
    .busy(busy2), .done(done2), .datapath_out(out2),
    .z_out(z2), .n_out(n2), .v_out(v2)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        z, n, v;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done1) begin
        if (q1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dut16 stray done: got pulse, required none");
        end else begin
          e = q1.pop_front();
          check("dut16 out", 32'(out1), 32'(e.out));
          check("dut16 zнv", 32'({z1, n1, v1}), 32'({e.z, e.n, e.v}));
        end
      end
      if (rst_n && done2) begin
        if (q2.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dut8 stray done: got pulse, required none");
        end else begin
          e = q2.pop_front();
          check("dut8 out", 32'(out2), 32'(e.out));
          check("dut8 znv", 32'({z2, n2, v2}), 32'({e.z, e.n, e.v}));
        end
      end
    end
  endtask

  task automatic issue(input bit u, input logic [1:0] m, input logic [1:0] o,
                       input logic [1:0] sh, input logic [3:0] d,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] im, input logic [15:0] eo,
                       input logic ez, input logic en, input logic ev);
    exp_t e;
    e = '{out: eo, z: ez, n: en, v: ev};
    if (!u) begin
      start1 = 1'b1; mode1 = m; aluop1 = o; shift1 = sh;
      rd1 = d[2:0]; rn1 = a[2:0]; rm1 = b[2:0]; imm1 = im;
      q1.push_back(e);
    end else begin
      start2 = 1'b1; mode2 = m; aluop2 = o; shift2 = sh;
      rd2 = d; rn2 = a; rm2 = b; imm2 = im[7:0];
      q2.push_back(e);
    end
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done(input bit u, input int exp_busy, input bit hold);
    int cnt = 0;
    @(posedge clk);
    #1;
    if (!hold) begin
      start1 = 1'b0;
      start2 = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u ? busy2 : busy1) cnt++;
      else break;
    end
    check(u ? "dut8 busy cycles" : "dut16 busy cycles", 32'(cnt), 32'(exp_busy));
    check(u ? "dut8 done pulse" : "dut16 done pulse",
          32'(u ? done2 : done1), 32'd1);
  endtask

  task automatic op(input bit u, input logic [1:0] m, input logic [1:0] o,
                    input logic [1:0] sh, input logic [3:0] d,
                    input logic [3:0] a, input logic [3:0] b,
                    input logic [15:0] im, input logic [15:0] eo,
                    input logic ez, input logic en, input logic ev,
                    input int nb);
    @(negedge clk);
    issue(u, m, o, sh, d, a, b, im, eo, ez, en, ev);
    wait_done(u, nb, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 0; mode1 = 0; aluop1 = 0; shift1 = 0;
    rd1 = 0; rn1 = 0; rm1 = 0; imm1 = 0;
    start2 = 0; mode2 = 0; aluop2 = 0; shift2 = 0;
    rd2 = 0; rn2 = 0; rm2 = 0; imm2 = 0;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset out", 32'(out1), 32'd0);
    check("reset flags", 32'({z1, n1, v1}), 32'd0);
    check("reset busy/done", 32'({busy1, done1}), 32'd0);
    check("reset dut8 out", 32'(out2), 32'd0);

    // test 1
    op(0, MOV,  0,      NS,  3, 0, 0, 0,        16'h0000, 0, 0, 0, 3);
    // test 2
    op(0, MOVI, 0,      NS,  0, 0, 0, 16'd7,    16'h0000, 0, 0, 0, 1);
    op(0, MOVI, 0,      NS,  1, 0, 0, 16'd2,    16'h0000, 0, 0, 0, 1);
    op(0, ALU,  OP_ADD, LSL, 2, 1, 0, 0,        16'd16,   0, 0, 0, 4);
    op(0, MOV,  0,      NS,  3, 0, 2, 0,        16'd16,   0, 0, 0, 3);
    // test 3
    op(0, CMP,  0,      NS,  0, 1, 1, 0,        16'd16,   1, 0, 0, 3);
    op(0, MOV,  0,      NS,  3, 0, 1, 0,        16'd2,    1, 0, 0, 3);
    // test 4
    op(0, MOVI, 0,      NS,  4, 0, 0, 16'h7FFF, 16'd2,    1, 0, 0, 1);
    op(0, MOVI, 0,      NS,  5, 0, 0, 16'h0001, 16'd2,    1, 0, 0, 1);
    op(0, ALU,  OP_ADD, NS,  6, 4, 5, 0,        16'h8000, 0, 1, 1, 4);
    op(0, MOV,  0,      ASR, 7, 0, 6, 0,        16'hC000, 0, 1, 1, 3);
    op(0, ALU,  OP_NOT, NS,  7, 0, 7, 0,        16'h3FFF, 0, 0, 0, 4);

    // test 5: start held through a busy op is not re-accepted
    @(negedge clk);
    issue(0, ALU, OP_SUB, NS, 2, 0, 1, 0, 16'd5, 0, 0, 0);
    wait_done(0, 4, 1'b1);
    start1 = 1'b0;
    @(negedge clk);
    check("held start ignored", 32'(busy1), 32'd0);
    // start in the done cycle is taken with no bubble
    @(negedge clk);
    issue(0, MOVI, 0, NS, 3, 0, 0, 16'd9, 16'd5, 0, 0, 0);
    wait_done(0, 1, 1'b0);
    issue(0, ALU, OP_AND, NS, 4, 0, 1, 0, 16'd2, 0, 0, 0);
    wait_done(0, 4, 1'b0);

    // test 6: reset during EXEC aborts
    @(negedge clk);
    issue(0, ALU, OP_ADD, NS, 2, 1, 0, 0, 16'd9, 0, 0, 0);
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy/done", 32'({busy1, done1}), 32'd0);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("abort clears out", 32'(out1), 32'd0);
    op(0, MOV,  0,      NS,  3, 0, 2, 0,        16'd0,    0, 0, 0, 3);

    // W=8, NREG=16, top index 15
    op(1, MOVI, 0,      NS,  0,  0,  0,  16'd7,  16'h00, 0, 0, 0, 1);
    op(1, MOVI, 0,      NS,  15, 0,  0,  16'd2,  16'h00, 0, 0, 0, 1);
    op(1, ALU,  OP_ADD, LSL, 2,  15, 0,  0,      16'h10, 0, 0, 0, 4);
    op(1, MOV,  0,      NS,  3,  0,  2,  0,      16'h10, 0, 0, 0, 3);
    op(1, MOVI, 0,      NS,  14, 0,  0,  16'h7F, 16'h10, 0, 0, 0, 1);
    op(1, MOVI, 0,      NS,  13, 0,  0,  16'h01, 16'h10, 0, 0, 0, 1);
    op(1, ALU,  OP_ADD, NS,  12, 14, 13, 0,      16'h80, 0, 1, 1, 4);
    op(1, MOV,  0,      LSR, 11, 0,  12, 0,      16'h40, 0, 1, 1, 3);

    @(negedge clk);
    check("scoreboard drained", 32'(q1.size() + q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
